// File: rtl/ahb_sram_pkg.sv
// Shared encodings and helpers for the banked AHB-lite SRAM subordinate.
// HTRANS/HSIZE codes, byte-lane mask generation, error-response FSM states.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ERR_OKAY = 2'd0,
        ERR_ONE  = 2'd1,
        ERR_TWO  = 2'd2
    } err_state_t;

    // NONSEQ and SEQ both carry bit 1; IDLE and BUSY never touch the array.
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

    // Lanes written by a transfer of the given size at the given byte offset (up to 8 lanes).
    function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] align);
        logic [7:0] base;
        case (size)
            HSIZE_BYTE: base = 8'h01;
            HSIZE_HALF: base = 8'h03;
            HSIZE_WORD: base = 8'h0f;
            default:    base = 8'hff;
        endcase
        return base << align;
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// Single-entry posted-write buffer: retires whenever its bank is not being read this cycle,
// captures hwdata if its own data phase is blocked, and forwards buffered bytes to matching reads.
module ahb_sram_wbuf
    import ahb_sram_pkg::*;
#(
    parameter int W_DATA  = 32,
    parameter int W_BSEL  = 1,
    parameter int W_ROW   = 10,
    parameter int W_ALIGN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_ap,
    input  logic                rd_ap,
    input  logic [W_BSEL-1:0]   ap_bank,
    input  logic [W_ROW-1:0]    ap_row,
    input  logic [W_ALIGN-1:0]  ap_align,
    input  logic [2:0]          ap_size,
    input  logic [W_DATA-1:0]   hwdata,
    input  logic                rd_dphase,
    input  logic [W_BSEL-1:0]   rd_bank,
    input  logic [W_ROW-1:0]    rd_row,
    input  logic [W_DATA-1:0]   sram_rdata,
    output logic                retire,
    output logic [W_BSEL-1:0]   wb_bank,
    output logic [W_ROW-1:0]    wb_row,
    output logic [W_DATA/8-1:0] wb_mask,
    output logic [W_DATA-1:0]   wb_wdata,
    output logic [W_DATA-1:0]   hrdata
);

    localparam int W_BYTES = W_DATA/8;

    logic               write_saved;
    logic               wbuf_vld;
    logic               in_dphase;
    logic [W_ALIGN-1:0] align_q;
    logic [2:0]         size_q;
    logic [W_DATA-1:0]  wdata_saved;
    logic               fwd;

    assign wb_mask  = W_BYTES'(byte_mask(size_q, 3'(align_q)));
    assign retire   = write_saved && !(rd_ap && (ap_bank == wb_bank));
    assign wb_wdata = wbuf_vld ? wdata_saved : hwdata;
    assign fwd      = rd_dphase && wbuf_vld && (rd_bank == wb_bank) && (rd_row == wb_row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_saved <= 1'b0;
            wbuf_vld    <= 1'b0;
            in_dphase   <= 1'b0;
            wb_bank     <= '0;
            wb_row      <= '0;
            align_q     <= '0;
            size_q      <= '0;
            wdata_saved <= '0;
        end else begin
            in_dphase <= wr_ap;
            // A new write always coincides with retirement of the old one: a write aphase is never a read.
            if (wr_ap) begin
                write_saved <= 1'b1;
                wbuf_vld    <= 1'b0;
                wb_bank     <= ap_bank;
                wb_row      <= ap_row;
                align_q     <= ap_align;
                size_q      <= ap_size;
            end else if (retire) begin
                write_saved <= 1'b0;
                wbuf_vld    <= 1'b0;
            end else if (in_dphase) begin
                wbuf_vld    <= 1'b1;
                wdata_saved <= hwdata;
            end
        end
    end

    always_comb begin
        hrdata = sram_rdata;
        for (int b = 0; b < W_BYTES; b++) begin
            if (fwd && wb_mask[b]) hrdata[8*b +: 8] = wdata_saved[8*b +: 8];
        end
    end

endmodule

// File: rtl/sram_wrapper.sv
// Single-port synchronous SRAM bank with per-byte write enables and registered read data.
// rdata only changes on a read access, so a write to the bank leaves the last read word visible.
module sram_wrapper #(
    parameter int W_DATA       = 32,
    parameter int DEPTH        = 1024,
    parameter     PRELOAD_FILE = ""
) (
    input  logic                     clk,
    inout  wire                      VDD,
    inout  wire                      VSS,
    input  logic                     chicken_cen_force,
    input  logic                     cs,
    input  logic                     we,
    input  logic [W_DATA/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W_DATA-1:0]        wdata,
    output logic [W_DATA-1:0]        rdata
);

    // Initial contents come from the macro's own load flow; the name is only carried through here.
    localparam bit PRELOAD_EN = (PRELOAD_FILE != "");

    logic [W_DATA-1:0] mem [DEPTH];
    logic              en;
    logic              unused;

    assign en     = cs || chicken_cen_force;
    assign unused = ^{VDD, VSS, PRELOAD_EN};

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < W_DATA/8; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ahb_sync_sram_banked.sv
// Zero-wait AHB-lite subordinate over N_BANKS word-interleaved SRAM banks with a posted write buffer.
// Optional AHB_SRAM_BANKED_ERR_EN adds a two-cycle ERROR for out-of-range address or oversize transfer.
module ahb_sync_sram_banked
    import ahb_sram_pkg::*;
#(
    parameter int W_DATA       = 32,
    parameter int W_ADDR       = 32,
    parameter int DEPTH        = 1 << 11,
    parameter int N_BANKS      = 2,
    parameter     PRELOAD_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire               VDD,
    inout  wire               VSS,
    input  logic              chicken_cen_force,
    output logic              ahbls_hready_resp,
    input  logic              ahbls_hready,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata
);

    localparam int W_BYTES    = W_DATA/8;
    localparam int W_BYTEADDR = $clog2(W_BYTES);
    localparam int W_WORD     = $clog2(DEPTH);
    localparam int W_BANK     = $clog2(N_BANKS);
    localparam int W_BSEL     = (W_BANK > 0) ? W_BANK : 1;
    localparam int W_ROW      = W_WORD - W_BANK;

    logic [W_WORD-1:0]  ap_word;
    logic [W_BSEL-1:0]  ap_bank;
    logic [W_ROW-1:0]   ap_row;
    logic               aphase, err_ap, rd_ap, wr_ap;
    logic               rd_dphase;
    logic [W_BSEL-1:0]  rd_bank_q;
    logic [W_ROW-1:0]   rd_row_q;
    logic               retire;
    logic [W_BSEL-1:0]  wb_bank;
    logic [W_ROW-1:0]   wb_row;
    logic [W_BYTES-1:0] wb_mask;
    logic [W_DATA-1:0]  wb_wdata;
    logic [W_DATA-1:0]  bank_rdata [N_BANKS];
    logic               unused;

    assign unused  = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_haddr};
    assign ap_word = ahbls_haddr[W_BYTEADDR +: W_WORD];

    // Low word bits pick the bank so sequential streams alternate banks.
    if (W_BANK > 0) begin : g_multi
        assign ap_bank = ap_word[W_BANK-1:0];
        assign ap_row  = ap_word[W_WORD-1:W_BANK];
    end else begin : g_single
        assign ap_bank = '0;
        assign ap_row  = ap_word;
    end

    assign aphase = is_active(ahbls_htrans) && ahbls_hready;
    assign rd_ap  = aphase && !ahbls_hwrite && !err_ap;
    assign wr_ap  = aphase &&  ahbls_hwrite && !err_ap;

`ifdef AHB_SRAM_BANKED_ERR_EN
    logic       addr_oob;
    logic       size_err;
    err_state_t err_state;

    if (W_ADDR > W_BYTEADDR + W_WORD) begin : g_oob
        assign addr_oob = |ahbls_haddr[W_ADDR-1:W_BYTEADDR+W_WORD];
    end else begin : g_no_oob
        assign addr_oob = 1'b0;
    end

    assign size_err = ahbls_hsize > 3'(W_BYTEADDR);
    assign err_ap   = aphase && (addr_oob || size_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_state         <= ERR_OKAY;
            ahbls_hready_resp <= 1'b1;
            ahbls_hresp       <= 1'b0;
        end else begin
            case (err_state)
                ERR_ONE: begin
                    err_state         <= ERR_TWO;
                    ahbls_hready_resp <= 1'b1;
                    ahbls_hresp       <= 1'b1;
                end
                default: begin
                    if (err_ap) begin
                        err_state         <= ERR_ONE;
                        ahbls_hready_resp <= 1'b0;
                        ahbls_hresp       <= 1'b1;
                    end else begin
                        err_state         <= ERR_OKAY;
                        ahbls_hready_resp <= 1'b1;
                        ahbls_hresp       <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    assign err_ap            = 1'b0;
    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dphase <= 1'b0;
            rd_bank_q <= '0;
            rd_row_q  <= '0;
        end else if (ahbls_hready) begin
            rd_dphase <= rd_ap;
            if (rd_ap) begin
                rd_bank_q <= ap_bank;
                rd_row_q  <= ap_row;
            end
        end
    end

    ahb_sram_wbuf #(
        .W_DATA  (W_DATA),
        .W_BSEL  (W_BSEL),
        .W_ROW   (W_ROW),
        .W_ALIGN (W_BYTEADDR)
    ) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_ap      (wr_ap),
        .rd_ap      (rd_ap),
        .ap_bank    (ap_bank),
        .ap_row     (ap_row),
        .ap_align   (ahbls_haddr[W_BYTEADDR-1:0]),
        .ap_size    (ahbls_hsize),
        .hwdata     (ahbls_hwdata),
        .rd_dphase  (rd_dphase),
        .rd_bank    (rd_bank_q),
        .rd_row     (rd_row_q),
        .sram_rdata (bank_rdata[rd_bank_q]),
        .retire     (retire),
        .wb_bank    (wb_bank),
        .wb_row     (wb_row),
        .wb_mask    (wb_mask),
        .wb_wdata   (wb_wdata),
        .hrdata     (ahbls_hrdata)
    );

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic hit_rd, hit_wr;

        // retire already excludes a same-bank read, so at most one of these is set.
        assign hit_rd = rd_ap  && (ap_bank == W_BSEL'(b));
        assign hit_wr = retire && (wb_bank == W_BSEL'(b));

        sram_wrapper #(
            .W_DATA       (W_DATA),
            .DEPTH        (DEPTH / N_BANKS),
            .PRELOAD_FILE (PRELOAD_FILE)
        ) u_sram (
            .clk               (clk),
            .VDD               (VDD),
            .VSS               (VSS),
            .chicken_cen_force (chicken_cen_force),
            .cs                (hit_rd || hit_wr),
            .we                (hit_wr),
            .be                (wb_mask),
            .addr              (hit_wr ? wb_row : ap_row),
            .wdata             (wb_wdata),
            .rdata             (bank_rdata[b])
        );
    end

endmodule

// File: tb/tb_ahb_sync_sram_banked.sv
// Directed bench for ahb_sync_sram_banked (N_BANKS=2, W_DATA=32, DEPTH=2048).
// Inputs change 1ns after posedge (that cycle is the aphase); outputs are sampled at the following negedge.
module tb_ahb_sync_sram_banked;
    import ahb_sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire         vdd, vss;
    logic        chicken = 1'b0;
    logic        hready_resp, hresp;
    wire         hready;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [2:0]  hsize = HSIZE_WORD;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    int          checks = 0;
    int          errors = 0;

    assign vdd    = 1'b1;
    assign vss    = 1'b0;
    assign hready = hready_resp;

    always #5 clk = ~clk;

    ahb_sync_sram_banked #(
        .W_DATA(32), .W_ADDR(32), .DEPTH(2048), .N_BANKS(2), .PRELOAD_FILE("")
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .VDD               (vdd),
        .VSS               (vss),
        .chicken_cen_force (chicken),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hready      (hready),
        .ahbls_hresp       (hresp),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hburst      (3'd0),
        .ahbls_hprot       (4'd0),
        .ahbls_hmastlock   (1'b0),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // wd is the data phase of the previous cycle's transfer.
    task automatic cyc(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
        @(posedge clk);
        #1;
        htrans = tr; hwrite = wr; haddr = a; hsize = sz; hwdata = wd;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hready_resp", 32'(hready_resp), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        rst_n = 1'b1;

        // Known contents for word1 (bank1 row0) and word2 (bank0 row1)
        cyc(HTRANS_NONSEQ, 1'b1, 32'h04, HSIZE_WORD, 32'h0);
        cyc(HTRANS_NONSEQ, 1'b1, 32'h08, HSIZE_WORD, 32'h0BADF00D);
        cyc(HTRANS_IDLE,   1'b0, 32'h00, HSIZE_WORD, 32'h12345678);
        cyc(HTRANS_IDLE,   1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("pre_b1r0", dut.g_bank[1].u_sram.mem[0], 32'h0BADF00D);
        chk("pre_b0r1", dut.g_bank[0].u_sram.mem[1], 32'h12345678);

        // 1: write then read same word
        cyc(HTRANS_NONSEQ, 1'b1, 32'h00, HSIZE_WORD, 32'h0);
        chk("t1_hready_w", 32'(hready_resp), 32'd1);
        cyc(HTRANS_NONSEQ, 1'b0, 32'h00, HSIZE_WORD, 32'hDEADBEEF);
        chk("t1_hready_r", 32'(hready_resp), 32'd1);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t1_rdata", hrdata, 32'hDEADBEEF);
        chk("t1_hready_d", 32'(hready_resp), 32'd1);

        // 2: forward, retire under a bank-1 read, then SRAM read
        cyc(HTRANS_NONSEQ, 1'b1, 32'h00, HSIZE_WORD, 32'h0);
        cyc(HTRANS_NONSEQ, 1'b0, 32'h00, HSIZE_WORD, 32'h11223344);
        cyc(HTRANS_NONSEQ, 1'b0, 32'h04, HSIZE_WORD, 32'h0);
        chk("t2_fwd", hrdata, 32'h11223344);
        cyc(HTRANS_NONSEQ, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t2_bank1", hrdata, 32'h0BADF00D);
        chk("t2_retired", dut.g_bank[0].u_sram.mem[0], 32'h11223344);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t2_sram", hrdata, 32'h11223344);

        // 3: byte write to lane 2, merged forward
        cyc(HTRANS_NONSEQ, 1'b1, 32'h02, HSIZE_BYTE, 32'h0);
        cyc(HTRANS_NONSEQ, 1'b0, 32'h00, HSIZE_WORD, 32'hABABABAB);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t3_merge", hrdata, 32'h11AB3344);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t3_sram", dut.g_bank[0].u_sram.mem[0], 32'h11AB3344);

        // 4: buffered write to bank0 held off by 20 same-bank reads
        cyc(HTRANS_NONSEQ, 1'b1, 32'h08, HSIZE_WORD, 32'h0);
        for (int i = 0; i < 20; i++) begin
            cyc(HTRANS_NONSEQ, 1'b0, (i == 10) ? 32'h08 : 32'h00, HSIZE_WORD,
                (i == 0) ? 32'hA5A50808 : 32'h0);
            if (i == 11) chk("t4_fwd", hrdata, 32'hA5A50808);
            else if (i > 0) chk("t4_rd", hrdata, 32'h11AB3344);
            if (i == 19) chk("t4_held", dut.g_bank[0].u_sram.mem[1], 32'h12345678);
        end
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t4_last", hrdata, 32'h11AB3344);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t4_retired", dut.g_bank[0].u_sram.mem[1], 32'hA5A50808);

        // 5: address beyond DEPTH
`ifdef AHB_SRAM_BANKED_ERR_EN
        cyc(HTRANS_NONSEQ, 1'b0, 32'h2000, HSIZE_WORD, 32'h0);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t5_r_err1_rdy", 32'(hready_resp), 32'd0);
        chk("t5_r_err1_resp", 32'(hresp), 32'd1);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t5_r_err2_rdy", 32'(hready_resp), 32'd1);
        chk("t5_r_err2_resp", 32'(hresp), 32'd1);
        cyc(HTRANS_NONSEQ, 1'b1, 32'h2000, HSIZE_WORD, 32'h0);
        chk("t5_okay_resp", 32'(hresp), 32'd0);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'hFFFFFFFF);
        chk("t5_w_err1_rdy", 32'(hready_resp), 32'd0);
        chk("t5_w_err1_resp", 32'(hresp), 32'd1);
        cyc(HTRANS_NONSEQ, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t5_w_err2_resp", 32'(hresp), 32'd1);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t5_rd_resp", 32'(hresp), 32'd0);
        chk("t5_rd_rdy", 32'(hready_resp), 32'd1);
        chk("t5_rd_data", hrdata, 32'h11AB3344);
        chk("t5_nowrite", dut.g_bank[0].u_sram.mem[0], 32'h11AB3344);
`else
        cyc(HTRANS_NONSEQ, 1'b0, 32'h2000, HSIZE_WORD, 32'h0);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t5_wrap_data", hrdata, 32'h11AB3344);
        chk("t5_wrap_resp", 32'(hresp), 32'd0);
        chk("t5_wrap_rdy", 32'(hready_resp), 32'd1);
`endif

        // 6: reset in the data phase of a buffered write discards it
        cyc(HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h0);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'hCAFEF00D);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t6_pre", dut.g_bank[0].u_sram.mem[2], 32'hCAFEF00D);
        cyc(HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h0);
        @(posedge clk);
        #1;
        htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'h55555555;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_rdy", 32'(hready_resp), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
        cyc(HTRANS_IDLE, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        chk("t6_rdata", hrdata, 32'hCAFEF00D);
        chk("t6_sram", dut.g_bank[0].u_sram.mem[2], 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
